unidade_controle_memoria: RTL
=============================

Name: unidade_controle_memoria

Overview:
- Control unit (Moore FSM plus internal timers) that sequences the memory-game datapath.
- Per round it replays the stored sequence on the LEDs, then waits for each player move.
- Each move is checked against memory, with a per-move timeout.
- Outcome is declared as win, loss or timeout. It drives the datapath's play counter, round-limit counter and move register; it sits beside the datapath inside jogo_desafio_memoria.

Parameters:
LED_ON_CYCLES, 500, cycles each sequence element is shown (exibe_leds=1)
LED_OFF_CYCLES, 250, dark gap after each shown element
TIMEOUT_FACIL, 5000, cycles allowed per move in easy mode
TIMEOUT_DIFICIL, 2500, cycles allowed per move in hard mode

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-low reset
jogar  input  1  start / restart request, level
dificuldade  input  1  mode select, 1 = hard; sampled only on leaving inicial or a final state
tem_jogada  input  1  one-cycle pulse from datapath edge detector: a button was pressed
igual  input  1  registered move equals memory word at current address
fimC  input  1  play counter equals current round limit
fimL  input  1  round limit is the last round
zeraC, contaC  output  1 each  clear / increment play counter
zeraL, contaL  output  1 each  clear / increment round limit
zeraR, registraR  output  1 each  clear / load move register
exibe_leds  output  1  datapath drives memory word onto leds
pronto, ganhou, perdeu, timeout  output  1 each  end-of-game flags
db_estado  output  4  current state code
db_dificuldade  output  1  latched mode

Behaviour:
- Timer: internal counter tmr, wide enough for max(TIMEOUT_FACIL, LED_ON_CYCLES, LED_OFF_CYCLES).
  - Cleared on every state change.
  - Increments every cycle the state is unchanged.
- Outputs: all are Moore, decoded from the state register.
- Reset (reset=0, async): state=inicial (0), tmr=0, dificuldade latch=0, all outputs 0.
- States, transitions and asserted outputs:
  - 0 inicial: no outputs. jogar=1 → 1; latch dificuldade.
  - 1 preparacao: zeraC, zeraL, zeraR. → 2.
  - 2 mostra_led: exibe_leds. Leaves when tmr==LED_ON_CYCLES-1 → 3, so LEDs are on exactly LED_ON_CYCLES cycles.
  - 3 apaga_led: leaves when tmr==LED_OFF_CYCLES-1. fimC=1 → 5, else → 4.
  - 4 proximo_led: contaC. → 2.
  - 5 prepara_jogadas: zeraC. → 6.
  - 6 espera_jogada: waits for a move.
    - tem_jogada=1 → 7.
    - Else if tmr==T-1 → 13, where T = TIMEOUT_DIFICIL if latched mode else TIMEOUT_FACIL.
    - tem_jogada wins over expiry in the same cycle.
  - 7 registra: registraR. → 8.
  - 8 compara: igual=0 → 12. Else fimC=1 and fimL=1 → 11. Else fimC=1 → 10. Else → 9.
  - 9 proxima_jogada: contaC. → 6, timer restarts, so every move gets a full T.
  - 10 proxima_rodada: contaL, zeraC. → 2.
  - 11 fim_ganhou: pronto, ganhou.
  - 12 fim_perdeu: pronto, perdeu.
  - 13 fim_timeout: pronto, timeout.
- Final states (11–13): hold until jogar=1 → 1; latch dificuldade. Flags stay asserted while in the final state.
- Codes 14, 15: unreachable; → 0 next cycle with all outputs 0.
- jogar is ignored in states 1–10. Holding jogar for several cycles must not restart the game.
- tem_jogada is ignored outside state 6. Moves made during replay are lost by design.
- Reset asserted mid-game returns to inicial immediately, regardless of the current state.

Decomposition:
- Package unidade_controle_pkg holds the 4-bit state encodings (values above) and the db_estado width.
- One sub-module, temporizador_controle: a parameterised up-counter with synchronous clear, an enable, and a terminal-compare output against a runtime limit input.
- The FSM instantiates it once and muxes the limit by state and mode.

Test Plan (LED_ON_CYCLES=4, LED_OFF_CYCLES=2, TIMEOUT_FACIL=10, TIMEOUT_DIFICIL=5):
1. reset=0 for 1 cycle, then release with jogar=0 for 10 cycles → db_estado=0, all outputs 0.
2. jogar=1 for 5 cycles, model fimC=1 → zeraC/zeraL/zeraR high one cycle; exibe_leds high exactly 4 cycles; 2 dark cycles; state reaches 6.
3. In state 6, pulse tem_jogada with igual=1, fimC=1, fimL=0 → states 7, 8, 10, then 2; contaL high one cycle.
4. In state 6 with dificuldade latched 0 and no tem_jogada → state 13 after exactly 10 cycles; pronto=timeout=1 held. Repeat with dificuldade=1 → 5 cycles.
5. tem_jogada and expiry in the same cycle → state 7, no timeout.
6. Move with igual=0 → state 12, perdeu=1. Then jogar=1 → state 1, flags clear. Assert reset while in state 2 → state 0 asynchronously, exibe_leds=0 before the next clock edge.

Source files
------------

// File: rtl/unidade_controle_memoria_pkg.sv
// Shared definitions for the memory-game control unit: state codes,
// debug-bus width and a small helper for sizing the internal timer.
package unidade_controle_pkg;

  localparam int ESTADO_W = 4;

  typedef enum logic [ESTADO_W-1:0] {
    INICIAL         = 4'd0,
    PREPARACAO      = 4'd1,
    MOSTRA_LED      = 4'd2,
    APAGA_LED       = 4'd3,
    PROXIMO_LED     = 4'd4,
    PREPARA_JOGADAS = 4'd5,
    ESPERA_JOGADA   = 4'd6,
    REGISTRA        = 4'd7,
    COMPARA         = 4'd8,
    PROXIMA_JOGADA  = 4'd9,
    PROXIMA_RODADA  = 4'd10,
    FIM_GANHOU      = 4'd11,
    FIM_PERDEU      = 4'd12,
    FIM_TIMEOUT     = 4'd13
  } estado_t;

  // Largest of four cycle counts; used to size the shared timer.
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/unidade_controle_memoria_if.sv
// Bus between the control unit and the datapath/top level. The control
// unit is the master: it receives status and requests, drives commands.
interface unidade_controle_memoria_if;
  logic jogar;
  logic dificuldade;
  logic tem_jogada;
  logic igual;
  logic fimC;
  logic fimL;
  logic zeraC;
  logic contaC;
  logic zeraL;
  logic contaL;
  logic zeraR;
  logic registraR;
  logic exibe_leds;
  logic pronto;
  logic ganhou;
  logic perdeu;
  logic timeout;
  logic [unidade_controle_pkg::ESTADO_W-1:0] db_estado;
  logic db_dificuldade;

  modport master (
    input  jogar, dificuldade, tem_jogada, igual, fimC, fimL,
    output zeraC, contaC, zeraL, contaL, zeraR, registraR, exibe_leds,
    output pronto, ganhou, perdeu, timeout, db_estado, db_dificuldade
  );

  modport slave (
    output jogar, dificuldade, tem_jogada, igual, fimC, fimL,
    input  zeraC, contaC, zeraL, contaL, zeraR, registraR, exibe_leds,
    input  pronto, ganhou, perdeu, timeout, db_estado, db_dificuldade
  );
endinterface

// File: rtl/unidade_controle_memoria_temporizador.sv
// Free-running up-counter with synchronous clear and enable; flags when
// the current count equals a limit supplied at run time.
module temporizador_controle #(
  parameter int W = 13
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         limpa,
  input  logic         habilita,
  input  logic [W-1:0] limite,
  output logic         fim
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear has priority over counting.
  always_comb begin
    cnt_d = cnt_q;
    if (limpa)         cnt_d = '0;
    else if (habilita) cnt_d = cnt_q + W'(1);
  end

  // Count register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign fim = (cnt_q == limite);

endmodule

// File: rtl/unidade_controle_memoria.sv
// Moore control FSM for the memory game: replays the stored sequence,
// collects and checks player moves with a per-move timeout, and reports
// win / loss / timeout.
module unidade_controle_memoria
  import unidade_controle_pkg::*;
#(
  parameter int LED_ON_CYCLES   = 500,
  parameter int LED_OFF_CYCLES  = 250,
  parameter int TIMEOUT_FACIL   = 5000,
  parameter int TIMEOUT_DIFICIL = 2500
) (
  input  logic                  clock,
  input  logic                  reset,
  unidade_controle_memoria_if.master bus
);

  localparam int TMR_MAX = max4(TIMEOUT_FACIL, TIMEOUT_DIFICIL, LED_ON_CYCLES, LED_OFF_CYCLES);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  estado_t            estado_q, estado_d;
  logic               dif_q, dif_d;
  logic [TMR_W-1:0]   limite;
  logic               tmr_fim;
  logic               tmr_limpa;

  // State and latched difficulty registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= INICIAL;
      dif_q    <= 1'b0;
    end else begin
      estado_q <= estado_d;
      dif_q    <= dif_d;
    end
  end

  // Next-state logic; difficulty is captured only when a game (re)starts.
  always_comb begin
    estado_d = estado_q;
    dif_d    = dif_q;
    case (estado_q)
      INICIAL, FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT: begin
        if (bus.jogar) begin
          estado_d = PREPARACAO;
          dif_d    = bus.dificuldade;
        end
      end
      PREPARACAO:      estado_d = MOSTRA_LED;
      MOSTRA_LED:      if (tmr_fim) estado_d = APAGA_LED;
      APAGA_LED:       if (tmr_fim) estado_d = bus.fimC ? PREPARA_JOGADAS : PROXIMO_LED;
      PROXIMO_LED:     estado_d = MOSTRA_LED;
      PREPARA_JOGADAS: estado_d = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        // A move arriving on the expiry cycle still counts.
        if (bus.tem_jogada) estado_d = REGISTRA;
        else if (tmr_fim)   estado_d = FIM_TIMEOUT;
      end
      REGISTRA:        estado_d = COMPARA;
      COMPARA: begin
        if (!bus.igual)                 estado_d = FIM_PERDEU;
        else if (bus.fimC && bus.fimL)  estado_d = FIM_GANHOU;
        else if (bus.fimC)              estado_d = PROXIMA_RODADA;
        else                            estado_d = PROXIMA_JOGADA;
      end
      PROXIMA_JOGADA:  estado_d = ESPERA_JOGADA;
      PROXIMA_RODADA:  estado_d = MOSTRA_LED;
      default:         estado_d = INICIAL;
    endcase
  end

  // Timer terminal value for the states that wait on it.
  always_comb begin
    limite = '0;
    case (estado_q)
      MOSTRA_LED:    limite = TMR_W'(LED_ON_CYCLES - 1);
      APAGA_LED:     limite = TMR_W'(LED_OFF_CYCLES - 1);
      ESPERA_JOGADA: limite = dif_q ? TMR_W'(TIMEOUT_DIFICIL - 1) : TMR_W'(TIMEOUT_FACIL - 1);
      default:       limite = '0;
    endcase
  end

  // Restart timing on every state change so each state sees a fresh count.
  assign tmr_limpa = (estado_d != estado_q);

  temporizador_controle #(.W(TMR_W)) u_tmr (
    .clock    (clock),
    .reset    (reset),
    .limpa    (tmr_limpa),
    .habilita (1'b1),
    .limite   (limite),
    .fim      (tmr_fim)
  );

  // Moore output decode from the current state.
  always_comb begin
    bus.zeraC      = 1'b0;
    bus.contaC     = 1'b0;
    bus.zeraL      = 1'b0;
    bus.contaL     = 1'b0;
    bus.zeraR      = 1'b0;
    bus.registraR  = 1'b0;
    bus.exibe_leds = 1'b0;
    bus.pronto     = 1'b0;
    bus.ganhou     = 1'b0;
    bus.perdeu     = 1'b0;
    bus.timeout    = 1'b0;
    case (estado_q)
      PREPARACAO: begin
        bus.zeraC = 1'b1;
        bus.zeraL = 1'b1;
        bus.zeraR = 1'b1;
      end
      MOSTRA_LED:      bus.exibe_leds = 1'b1;
      PROXIMO_LED:     bus.contaC     = 1'b1;
      PREPARA_JOGADAS: bus.zeraC      = 1'b1;
      REGISTRA:        bus.registraR  = 1'b1;
      PROXIMA_JOGADA:  bus.contaC     = 1'b1;
      PROXIMA_RODADA: begin
        bus.contaL = 1'b1;
        bus.zeraC  = 1'b1;
      end
      FIM_GANHOU: begin
        bus.pronto = 1'b1;
        bus.ganhou = 1'b1;
      end
      FIM_PERDEU: begin
        bus.pronto = 1'b1;
        bus.perdeu = 1'b1;
      end
      FIM_TIMEOUT: begin
        bus.pronto  = 1'b1;
        bus.timeout = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.db_estado      = estado_q;
  assign bus.db_dificuldade = dif_q;

endmodule
